icache_blk: RTL

Parametrised direct-mapped instruction cache with multi-word blocks, replacing the single-word icache between the datapath fetch port and the memory controller's instruction channel. A miss triggers a fill FSM that reads every word of the block sequentially from memory, then installs the whole line. Also adds a whole-cache invalidate (`iflush`) and a pipeline-abort path.

---
 rtl/cpu_types_pkg.sv | 4 +
 rtl/icache_pkg.sv | 8 +
 rtl/icache_fill_ctrl.sv | 89 ++++++++
 rtl/icache_blk.sv | 123 ++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared datapath types used across the CPU memory hierarchy.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/icache_pkg.sv
// Instruction cache shared definitions: fill FSM state encoding.
package icache_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } icache_state_t;
endpackage

// File: rtl/icache_fill_ctrl.sv
// Miss fill controller: fetches a whole block word by word into a line buffer,
// then pulses install for one cycle unless aborted or flushed.
module icache_fill_ctrl
    import cpu_types_pkg::*;
    import icache_pkg::*;
#(
    parameter int BLOCK_WORDS = 2,
    parameter int LW          = 29
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [LW-1:0]            miss_line_i,
    input  logic                     abort_i,
    input  logic                     flush_i,
    input  logic                     iwait_i,
    input  word_t                    iload_i,
    output logic                     iren_o,
    output word_t                    iaddr_o,
    output logic                     fill_start_o,
    output logic                     install_o,
    output logic [LW-1:0]            install_line_o,
    output word_t [BLOCK_WORDS-1:0]  install_data_o
);
    localparam int WOFF = $clog2(BLOCK_WORDS);
    localparam int CW   = (WOFF > 0) ? WOFF : 1;

    icache_state_t           state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [LW-1:0]           line_q, line_d;
    word_t [BLOCK_WORDS-1:0] buf_q, buf_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        buf_d        = buf_q;
        iren_o       = 1'b0;
        iaddr_o      = '0;
        fill_start_o = 1'b0;
        install_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d      = FILL;
                    cnt_d        = '0;
                    line_d       = miss_line_i;
                    fill_start_o = 1'b1;
                end
            end
            FILL: begin
                iren_o  = 1'b1;
                iaddr_o = (32'(line_q) << (WOFF + 2)) | (32'(cnt_q) << 2);
                // A redirect or flush wins over a word arriving in the same cycle.
                if (flush_i || abort_i) begin
                    state_d = IDLE;
                end else if (!iwait_i) begin
                    buf_d[cnt_q] = iload_i;
                    cnt_d        = cnt_q + 1'b1;
                    if (cnt_q == CW'(BLOCK_WORDS - 1)) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                install_o = !flush_i && !abort_i;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign install_line_o = line_q;
    assign install_data_o = buf_q;
endmodule

// File: rtl/icache_blk.sv
// Direct-mapped multi-word-block instruction cache with flush and abort.
// Optional hit/miss counters are compiled in with ICACHE_PERF_EN.
module icache_blk
    import cpu_types_pkg::*;
    import icache_pkg::*;
#(
    parameter int SETS        = 16,
    parameter int BLOCK_WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        pcRST,
    input  logic        iflush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int WOFF = $clog2(BLOCK_WORDS);
    localparam int CW   = (WOFF > 0) ? WOFF : 1;
    localparam int IDX  = $clog2(SETS);
    localparam int LW   = 30 - WOFF;
    localparam int TW   = LW - IDX;

    logic [SETS-1:0]         valid_q;
    logic [TW-1:0]           tag_q  [SETS];
    word_t [BLOCK_WORDS-1:0] data_q [SETS];

    logic [IDX-1:0] req_idx;
    logic [TW-1:0]  req_tag;
    logic [CW-1:0]  req_woff;
    logic [1:0]     unused_byte_off;

    logic                    fill_start, install;
    logic [LW-1:0]           install_line;
    word_t [BLOCK_WORDS-1:0] install_data;
    logic [IDX-1:0]          ins_idx;

    assign req_idx         = imemaddr[WOFF+2 +: IDX];
    assign req_tag         = imemaddr[31 -: TW];
    assign unused_byte_off = imemaddr[1:0];

    if (WOFF > 0) begin : g_woff
        assign req_woff = imemaddr[2 +: CW];
    end else begin : g_no_woff
        assign req_woff = '0;
    end

    assign ihit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign imemload = ihit ? data_q[req_idx][req_woff] : '0;

    icache_fill_ctrl #(
        .BLOCK_WORDS(BLOCK_WORDS),
        .LW         (LW)
    ) u_fill (
        .clk_i         (CLK),
        .rst_i         (RST),
        .start_i       (imemREN && !pcRST && !iflush && !ihit),
        .miss_line_i   (imemaddr[31:WOFF+2]),
        .abort_i       (pcRST),
        .flush_i       (iflush),
        .iwait_i       (iwait),
        .iload_i       (iload),
        .iren_o        (iREN),
        .iaddr_o       (iaddr),
        .fill_start_o  (fill_start),
        .install_o     (install),
        .install_line_o(install_line),
        .install_data_o(install_data)
    );

    assign ins_idx = install_line[IDX-1:0];

    // Flush only drops valid bits; stale tags/data are harmless once invalid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                tag_q[s]  <= '0;
                data_q[s] <= '0;
            end
        end else if (iflush) begin
            valid_q <= '0;
        end else if (install) begin
            valid_q[ins_idx] <= 1'b1;
            tag_q[ins_idx]   <= install_line[LW-1:IDX];
            data_q[ins_idx]  <= install_data;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_q, miss_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (imemREN && ihit && !pcRST && (hit_q != 32'hFFFF_FFFF)) begin
                hit_q <= hit_q + 32'd1;
            end
            if (fill_start && (miss_q != 32'hFFFF_FFFF)) begin
                miss_q <= miss_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    logic unused_fill_start;
    assign unused_fill_start = fill_start;
`endif
endmodule
